// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, instruction opcode constants and the decoded bundle type
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_NOR = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1000,
    ALU_SLT = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        illegal;
  } dec_bundle_t;

  // funct3 mapping shared by OP and OP-IMM; 011 (unsigned compare) is rejected by the caller
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    case (funct3)
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      3'b111:  base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry in-order skid buffer with registered ready and flush
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         push;
  logic         pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // ready is the next occupancy's free-slot flag, so out_ready never reaches in_ready combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      count_q  <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      count_q  <= count_d;
      in_ready <= (count_d < 2'd2);
      if (pop) begin
        head_q <= (count_q == 2'd2) ? tail_q : in_data;
      end else if (push) begin
        if (count_q == 2'd0) head_q <= in_data;
        else                 tail_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I-style integer decode into ALU controls, buffered by a skid buffer
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_use_imm,
  output logic        out_reg_write,
  output logic        out_illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        legal;
  alu_op_e     op;
  logic [31:0] imm;
  logic        use_imm;
  dec_bundle_t dec;
  dec_bundle_t head;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    legal   = 1'b0;
    op      = ALU_ADD;
    imm     = '0;
    use_imm = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_ZERO && funct3 != 3'b011) begin
          legal = 1'b1;
          op    = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          legal = 1'b1;
          op    = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          legal = 1'b1;
          op    = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        use_imm = 1'b1;
        case (funct3)
          3'b001: begin
            legal = (funct7 == F7_ZERO);
            op    = ALU_SLL;
            imm   = {27'b0, in_instr[24:20]};
          end
          3'b101: begin
            legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            imm   = {27'b0, in_instr[24:20]};
          end
          3'b011: legal = 1'b0;
          default: begin
            legal = 1'b1;
            op    = base_op(funct3);
            imm   = {{20{in_instr[31]}}, in_instr[31:20]};
          end
        endcase
      end
      OPC_CUSTOM0: begin
        if (funct3 == 3'b000 && funct7 == F7_ZERO) begin
          legal = 1'b1;
          op    = ALU_NOR;
        end
      end
      default: legal = 1'b0;
    endcase

    // illegal encodings still travel downstream, scrubbed to a harmless bundle so execute can trap
    dec           = '0;
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];
    dec.alu_op    = legal ? op : ALU_ADD;
    dec.imm       = legal ? imm : 32'd0;
    dec.use_imm   = legal && use_imm;
    dec.reg_write = legal && (in_instr[11:7] != 5'd0);
    dec.illegal   = !legal;
  end

  skid_buffer #(
    .W($bits(dec_bundle_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_alu_op    = head.alu_op;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_imm       = head.imm;
  assign out_use_imm   = head.use_imm;
  assign out_reg_write = head.reg_write;
  assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - directed-vector bench for alu_decode_stage with a mnemonic-level model and scoreboard
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic        out_reg_write;
  logic        out_illegal;

  int n_vec = 0;
  int n_err = 0;
  logic [53:0] q[$];
  int rd_log[$];
  logic [53:0] dut_b;

  alu_decode_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_op    (out_alu_op),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_use_imm   (out_use_imm),
    .out_reg_write (out_reg_write),
    .out_illegal   (out_illegal)
  );

  always #5 clk = ~clk;

  assign dut_b = {out_alu_op, out_rs1, out_rs2, out_rd, out_imm, out_use_imm, out_reg_write, out_illegal};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic string mnem(input logic [31:0] i);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = i[6:0];
    f3  = i[14:12];
    f7  = i[31:25];
    if (opc == 7'h33 && f7 == 7'h00) begin
      case (f3)
        3'd0: return "add";
        3'd1: return "sll";
        3'd2: return "slt";
        3'd4: return "xor";
        3'd5: return "srl";
        3'd6: return "or";
        3'd7: return "and";
        default: return "";
      endcase
    end
    if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) return "sub";
    if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd5) return "sra";
    if (opc == 7'h13) begin
      if (f3 == 3'd0) return "addi";
      if (f3 == 3'd2) return "slti";
      if (f3 == 3'd4) return "xori";
      if (f3 == 3'd6) return "ori";
      if (f3 == 3'd7) return "andi";
      if (f3 == 3'd1 && f7 == 7'h00) return "slli";
      if (f3 == 3'd5 && f7 == 7'h00) return "srli";
      if (f3 == 3'd5 && f7 == 7'h20) return "srai";
    end
    if (opc == 7'h0B && f3 == 3'd0 && f7 == 7'h00) return "nor";
    return "";
  endfunction

  // expected bundle packed as {op, rs1, rs2, rd, imm, use_imm, reg_write, illegal}
  function automatic logic [53:0] model(input logic [31:0] i);
    string m;
    logic [3:0]  op;
    logic [31:0] imm;
    logic ui, ill, rw;
    m   = mnem(i);
    ill = (m == "");
    case (m)
      "sub":           op = 4'd1;
      "and", "andi":   op = 4'd2;
      "or", "ori":     op = 4'd3;
      "xor", "xori":   op = 4'd4;
      "nor":           op = 4'd5;
      "sll", "slli":   op = 4'd6;
      "srl", "srli":   op = 4'd7;
      "sra", "srai":   op = 4'd8;
      "slt", "slti":   op = 4'd9;
      default:         op = 4'd0;
    endcase
    ui = !ill && (m.substr(m.len() - 1, m.len() - 1) == "i");
    if (!ui) imm = 32'd0;
    else if (m == "slli" || m == "srli" || m == "srai") imm = {27'd0, i[24:20]};
    else imm = 32'($signed(i[31:20]));
    rw = !ill && (i[11:7] != 5'd0);
    return {op, i[19:15], i[24:20], i[11:7], imm, ui, rw, ill};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      int sz;
      sz = q.size();
      check("out_valid", out_valid, sz != 0);
      check("in_ready", in_ready, sz < 2);
      if (sz != 0 && out_valid) check("bundle", dut_b, q[0]);
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && sz != 0) begin
          rd_log.push_back(int'(out_rd));
          void'(q.pop_front());
        end
        if (in_valid && sz < 2) q.push_back(model(in_instr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bp_start;
    int hits;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; flush = 1'b0; out_ready = 1'b1;

    check("model_add", model(32'h002081B3), {4'h0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 1'b0});
    check("model_addi", model(32'hFFF00093), {4'h0, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0});
    check("model_srai", model(32'h40415113), {4'h8, 5'd2, 5'd4, 5'd2, 32'h4, 1'b1, 1'b1, 1'b0});
    check("model_bad_f7", model(32'h42415113), {4'h0, 5'd2, 5'd4, 5'd2, 32'h0, 1'b0, 1'b0, 1'b1});
    check("model_sltu", model(rtype(7'h00, 5'd2, 5'd1, 3'b011, 5'd3)), {4'h0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 1'b1});

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", dut_b, 0);
    rst = 1'b0;
    tick();

    in_valid = 1'b1; in_instr = 32'h002081B3;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_op", out_alu_op, 4'h0);
    check("add_rs1", out_rs1, 5'd1);
    check("add_rs2", out_rs2, 5'd2);
    check("add_rd", out_rd, 5'd3);
    check("add_use_imm", out_use_imm, 0);
    check("add_reg_write", out_reg_write, 1);
    tick();

    in_valid = 1'b1; in_instr = 32'h407302B3;
    tick();
    in_instr = 32'hFFF00093;
    @(negedge clk);
    check("sub_op", out_alu_op, 4'h1);
    check("sub_rd", out_rd, 5'd5);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("addi_op", out_alu_op, 4'h0);
    check("addi_imm", out_imm, 32'hFFFFFFFF);
    check("addi_use_imm", out_use_imm, 1);
    tick();

    in_valid = 1'b1; in_instr = 32'h40415113;
    tick();
    in_instr = 32'h42415113;
    @(negedge clk);
    check("srai_op", out_alu_op, 4'h8);
    check("srai_imm", out_imm, 32'h4);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bad_illegal", out_illegal, 1);
    check("bad_reg_write", out_reg_write, 0);
    tick();

    in_valid = 1'b1; in_instr = rtype(7'h00, 5'd1, 5'd2, 3'b110, 5'd9);
    tick();
    in_instr = {7'h00, 5'd4, 5'd3, 3'b000, 5'd8, 7'h0B};
    tick();
    in_valid = 1'b0;
    repeat (2) tick();

    bp_start = rd_log.size();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = rtype(7'h00, 5'd1, 5'd2, 3'b000, 5'd10);
    tick();
    in_instr = rtype(7'h00, 5'd1, 5'd2, 3'b100, 5'd11);
    tick();
    in_instr = rtype(7'h00, 5'd1, 5'd2, 3'b110, 5'd12);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_head_rd", out_rd, 5'd10);
    repeat (2) tick();
    @(negedge clk);
    check("bp_hold_ready", in_ready, 0);
    check("bp_hold_rd", out_rd, 5'd10);
    tick();
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    check("bp_third_accepted", acc, 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_count", rd_log.size() - bp_start, 3);
    if (rd_log.size() - bp_start == 3) begin
      check("bp_order0", rd_log[bp_start], 10);
      check("bp_order1", rd_log[bp_start + 1], 11);
      check("bp_order2", rd_log[bp_start + 2], 12);
    end

    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = rtype(7'h00, 5'd1, 5'd2, 3'b000, 5'd20);
    tick();
    in_instr = rtype(7'h20, 5'd1, 5'd2, 3'b000, 5'd21);
    tick();
    in_instr = rtype(7'h00, 5'd1, 5'd2, 3'b111, 5'd22);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    in_valid = 1'b1; in_instr = rtype(7'h00, 5'd1, 5'd2, 3'b001, 5'd23);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_drop_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (4) tick();
    hits = 0;
    foreach (rd_log[k]) if (rd_log[k] >= 20 && rd_log[k] <= 23) hits++;
    check("flush_never_seen", hits, 0);

    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = rtype(7'h00, 5'd1, 5'd2, 3'b000, 5'd7);
    tick();
    in_instr = rtype(7'h00, 5'd1, 5'd2, 3'b100, 5'd6);
    tick();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_data", dut_b, 0);
    #4 rst = 1'b0;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00000013;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("nop_valid", out_valid, 1);
    check("nop_op", out_alu_op, 4'h0);
    check("nop_rd", out_rd, 5'd0);
    check("nop_reg_write", out_reg_write, 0);
    check("nop_illegal", out_illegal, 0);
    repeat (3) tick();
    check("sb_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
